// File: rtl/risc16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc16_pkg
//  Description : Shared types and constants for the RiSC-16 data-memory
//                responder: word type, request/response records, FSM state
//                encoding, memory opcodes and an address range helper.
//  Revision    : 1.0  initial release
// ============================================================================
package risc16_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   // Responder control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // RiSC-16 memory opcodes served by this target
   localparam logic [2:0] OP_LW = 3'b101;
   localparam logic [2:0] OP_SW = 3'b100;

   // Request fields captured at the accept edge
   typedef struct packed {
      logic  we;
      word_t addr;
      word_t wdata;
   } req_t;

   // Response fields held stable while the response is pending
   typedef struct packed {
      word_t rdata;
      logic  err;
   } resp_t;

   // Full-width unsigned compare; no aliasing of high addresses onto low words
   function automatic logic addr_in_range(input word_t addr, input int unsigned depth);
      return {{(32-WORD_W){1'b0}}, addr} < depth;
   endfunction

endpackage : risc16_pkg
`default_nettype wire

// File: rtl/risc16_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : risc16_wait_counter
//  Description : Wait-state down counter. Loads a start value, decrements on
//                request and reports done while the count is zero. Never
//                underflows.
//  Revision    : 1.0  initial release
// ============================================================================
module risc16_wait_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load has priority over decrement; hold at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule : risc16_wait_counter
`default_nettype wire

// File: rtl/risc16_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : risc16_dmem_responder
//  Description : Single-outstanding data-memory target for the RiSC-16 core.
//                Accepts a load/store over valid/ready, waits LATENCY cycles,
//                commits to a DEPTH-word array and holds the response until
//                the requester takes it.
//  Revision    : 1.0  initial release
// ============================================================================
module risc16_dmem_responder
   import risc16_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int unsigned    CNT_W    = 4;
   localparam int unsigned    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

   state_e state_q;
   state_e state_d;
   req_t   req_q;
   req_t   req_d;
   resp_t  resp_q;
   resp_t  resp_d;

   logic   w_accept;
   logic   w_commit;
   logic   w_cnt_dec;
   logic   w_cnt_done;
   logic   w_in_range;
   logic   w_mem_we;
   logic [IDX_W-1:0] w_idx;
   word_t  w_rd_word;
   word_t  w_words [DEPTH];

   // ------------------------------------------------------------------
   // Wait-state countdown. Loaded with LATENCY on accept; the commit
   // happens on the first WAIT edge that finds the count at zero, so a
   // request accepted at edge N responds after edge N+1+LATENCY.
   // ------------------------------------------------------------------
   risc16_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (w_accept),
      .dec_i      (w_cnt_dec),
      .load_val_i (LAT_LOAD),
      .done_o     (w_cnt_done)
   );

   // Next-state and control strobes for IDLE -> WAIT -> RESP -> IDLE
   always_comb begin
      state_d   = state_q;
      w_accept  = 1'b0;
      w_commit  = 1'b0;
      w_cnt_dec = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               w_accept = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_cnt_done) begin
               w_commit = 1'b1;
               state_d  = ST_RESP;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_RESP: begin
            // A new request seen here waits for the following IDLE cycle
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Address decode of the captured request
   assign w_in_range = addr_in_range(req_q.addr, DEPTH);
   assign w_idx      = req_q.addr[IDX_W-1:0];
   assign w_rd_word  = w_words[w_idx];
   assign w_mem_we   = w_commit && req_q.we && w_in_range;

   // Request capture on accept and response formation on commit
   always_comb begin
      req_d  = req_q;
      resp_d = resp_q;
      if (w_accept) begin
         req_d.we    = req_we;
         req_d.addr  = req_addr;
         req_d.wdata = req_wdata;
      end
      if (w_commit) begin
         if (!w_in_range) begin
            resp_d.rdata = '0;
            resp_d.err   = 1'b1;
         end else if (req_q.we) begin
            resp_d.rdata = req_q.wdata;
            resp_d.err   = 1'b0;
         end else begin
            resp_d.rdata = w_rd_word;
            resp_d.err   = 1'b0;
         end
      end
   end

   // Request and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q  <= '0;
         resp_q <= '0;
      end else begin
         req_q  <= req_d;
         resp_q <= resp_d;
      end
   end

   // ------------------------------------------------------------------
   // Storage array, one register per word so reset can clear it all.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_mem
      word_t word_q;
      word_t word_d;

      // Next value of this word: written only by an in-range store commit
      always_comb begin
         word_d = word_q;
         if (w_mem_we && (w_idx == IDX_W'(gi))) begin
            word_d = req_q.wdata;
         end
      end

      // Word register, cleared by reset
      always_ff @(posedge clk) begin
         if (rst) begin
            word_q <= '0;
         end else begin
            word_q <= word_d;
         end
      end

      assign w_words[gi] = word_q;
   end

   // Handshake and status outputs, all decoded from registered state
   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign busy       = (state_q != ST_IDLE);
   assign resp_rdata = resp_q.rdata;
   assign resp_err   = resp_q.err;

endmodule : risc16_dmem_responder
`default_nettype wire
